reaction_timer_ctrl: RTL and testbench
======================================

REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, Clock cycles per 1 ms tick (minimum 2).
REQ-002 SHALL have parameter MIN_WAIT_MS, default 1000, minimum random pre-stimulus delay in ms (1..7167).
REQ-003 SHALL have port Clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port ResetN  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port Start  in  1  debounced start button, synchronous level.
REQ-006 SHALL have port Button  in  1  debounced reaction button, synchronous level.
REQ-007 SHALL have port CntValue  in  13  current value of the external 13-bit up-counter.
REQ-008 SHALL have port CntEnable  out  1  count-enable to the counter, one Clock wide per ms tick.
REQ-009 SHALL have port CntReset  out  1  active-high clear to the counter.
REQ-010 SHALL have port Led  out  1  stimulus lamp.
REQ-011 SHALL have port Result  out  13  latched reaction time in ms.
REQ-012 SHALL have port ResultValid, Foul, Timeout  out  1 each  terminal status flags.
REQ-013 SHALL have port Busy  out  1  high in ARM or GO.

Function
REQ-014 SHALL implement FSM states IDLE, ARM, GO, DONE, FOUL, TIMEOUT.
REQ-015 SHALL detect rising edges of Start and Button with one registered sample each; only edges act, held levels are ignored.
REQ-016 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every Clock in every state, never all-zero.
REQ-017 SHALL run a prescaler counting 0..TICK_DIV-1 that emits a one-cycle tick on wrap; it is cleared on every entry to ARM.
REQ-018 IDLE/DONE/FOUL/TIMEOUT + Start edge SHALL go to ARM, load Wait = MIN_WAIT_MS + LFSR[9:0], and assert CntReset for that one cycle.
REQ-019 Entry to ARM SHALL clear ResultValid, Foul and Timeout. Result SHALL hold its last value.
REQ-020 ARM SHALL decrement Wait on each tick.
REQ-021 ARM SHALL go to GO on the tick where Wait equals 1, giving a total delay of Wait ms ±1 Clock.
REQ-022 ARM + Button edge SHALL go to FOUL and set Foul=1. A Button edge in the same cycle as expiry SHALL also go to FOUL.
REQ-023 GO SHALL hold Led=1 and set CntEnable = tick. Led SHALL be 0 in all other states.
REQ-024 GO + Button edge SHALL go to DONE, latch Result = CntValue, and set ResultValid=1. CntEnable SHALL be forced 0 in that cycle, even on a tick.
REQ-025 GO with CntValue = 8191 on a tick SHALL go to TIMEOUT, set Timeout=1, and force CntEnable=0 so the counter never wraps.
REQ-026 A Button edge and the 8191 tick in the same cycle SHALL go to DONE with Result=8191.
REQ-027 Start edges during ARM or GO SHALL be ignored.
REQ-028 Result SHALL change only on the GO->DONE transition.
REQ-029 All outputs SHALL be registered except CntEnable, which is tick AND state==GO with no extra latency.

Reset
REQ-030 While ResetN=0, state SHALL be IDLE and Result=0.
REQ-031 While ResetN=0, CntEnable=0, Led=0, ResultValid=0, Foul=0, Timeout=0 and Busy=0.
REQ-032 While ResetN=0, CntReset SHALL be 1 to hold the counter clear.
REQ-033 While ResetN=0, the prescaler SHALL be 0, Wait SHALL be 0, the LFSR SHALL be 16'hACE1 and the edge detectors SHALL be 0.
REQ-034 Reset asserted mid-ARM or mid-GO SHALL abort immediately with no Result update.
REQ-035 After ResetN deassertion the block SHALL stay in IDLE until a fresh Start edge; a Start held high through reset SHALL not count as an edge.

Verification (TICK_DIV=4, MIN_WAIT_MS=2, real 13-bit counter attached)
REQ-036 Normal round: Start pulse -> CntReset for 1 cycle, Busy=1, Led rises after (2+LFSR[9:0]) ticks. Button press 25 ticks after Led -> DONE, Result=25, ResultValid=1, Led=0.
REQ-037 False start: Button edge during ARM -> Foul=1, Led never rises, CntEnable never pulses, Result unchanged.
REQ-038 Timeout: no Button in GO -> counter reaches 8191, Timeout=1, CntEnable stays 0 afterward, CntValue remains 8191.
REQ-039 Simultaneous events: Button edge on the expiry tick -> FOUL. Button edge on the 8191 tick -> DONE with Result=8191.
REQ-040 Reset mid-GO: drive ResetN low at CntValue=100 -> all outputs at reset values within the same cycle (async); a Start held high through reset -> still IDLE.
REQ-041 Restart: Start edge from DONE -> flags cleared, new round, a different wait length from the LFSR; Start edges in ARM/GO -> no effect.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random pre-stimulus delay from an LFSR, ms ticks
// from a Clock prescaler, and control of an external 13-bit ms up-counter.
module reaction_timer_ctrl #(
  parameter int TICK_DIV    = 50000,
  parameter int MIN_WAIT_MS = 1000
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic        Button,
  input  logic [12:0] CntValue,
  output logic        CntEnable,
  output logic        CntReset,
  output logic        Led,
  output logic [12:0] Result,
  output logic        ResultValid,
  output logic        Foul,
  output logic        Timeout,
  output logic        Busy
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [12:0]     WAIT_MIN  = 13'(MIN_WAIT_MS);
  localparam logic [12:0]     CNT_MAX   = 13'h1FFF;

  typedef enum logic [2:0] {IDLE, ARM, GO, DONE, FOUL, TIMEOUT} state_t;

  state_t        state_q, state_d;
  logic          start_q, button_q, primed_q;
  logic          start_edge, button_edge;
  logic [15:0]   lfsr_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [12:0]   wait_q;
  logic          arm_load, wait_dec, latch_result, cnt_en;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic cnt_saturated(input logic [12:0] v);
    return (v == CNT_MAX);
  endfunction

  // primed_q masks the first sample after reset so a level held through reset is not an edge
  assign start_edge  = primed_q & Start  & ~start_q;
  assign button_edge = primed_q & Button & ~button_q;
  assign tick        = (presc_q == PRESC_MAX);
  assign CntEnable   = cnt_en;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    arm_load     = 1'b0;
    wait_dec     = 1'b0;
    latch_result = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE, DONE, FOUL, TIMEOUT: begin
        if (start_edge) begin
          state_d  = ARM;
          arm_load = 1'b1;
        end
      end
      ARM: begin
        if (button_edge) begin
          state_d = FOUL;
        end else if (tick) begin
          if (wait_q == 13'd1) state_d = GO;
          else                 wait_dec = 1'b1;
        end
      end
      GO: begin
        // a press on the saturation tick still wins and latches 8191
        if (button_edge) begin
          state_d      = DONE;
          latch_result = 1'b1;
        end else if (tick) begin
          if (cnt_saturated(CntValue)) state_d = TIMEOUT;
          else                         cnt_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      start_q  <= 1'b0;
      button_q <= 1'b0;
      primed_q <= 1'b0;
      lfsr_q   <= 16'hACE1;
      presc_q  <= '0;
      wait_q   <= '0;
    end else begin
      start_q  <= Start;
      button_q <= Button;
      primed_q <= 1'b1;
      lfsr_q   <= lfsr_step(lfsr_q);
      if (arm_load || tick) presc_q <= '0;
      else                  presc_q <= presc_q + 1'b1;
      if (arm_load)      wait_q <= WAIT_MIN + {3'b000, lfsr_q[9:0]};
      else if (wait_dec) wait_q <= wait_q - 13'd1;
    end
  end

  // flags follow the next state so they appear with the transition and clear on entry to ARM
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Led         <= 1'b0;
      Busy        <= 1'b0;
      ResultValid <= 1'b0;
      Foul        <= 1'b0;
      Timeout     <= 1'b0;
      CntReset    <= 1'b1;
      Result      <= '0;
    end else begin
      Led         <= (state_d == GO);
      Busy        <= (state_d == ARM) || (state_d == GO);
      ResultValid <= (state_d == DONE);
      Foul        <= (state_d == FOUL);
      Timeout     <= (state_d == TIMEOUT);
      CntReset    <= arm_load;
      if (latch_result) Result <= CntValue;
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl with an attached 13-bit counter, randomized rounds,
// and a scoreboard of expected round outcomes checked by an independent monitor.
module tb_reaction_timer_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int MIN_WAIT_MS = 2;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic        Button = 1'b0;
  logic [12:0] CntValue;
  logic        CntEnable, CntReset, Led, ResultValid, Foul, Timeout, Busy;
  logic [12:0] Result;

  reaction_timer_ctrl #(.TICK_DIV(TICK_DIV), .MIN_WAIT_MS(MIN_WAIT_MS)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Button(Button),
    .CntValue(CntValue), .CntEnable(CntEnable), .CntReset(CntReset), .Led(Led),
    .Result(Result), .ResultValid(ResultValid), .Foul(Foul), .Timeout(Timeout),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // external counter, with a bench-only preload to reach the top of range quickly
  logic        preload_req = 1'b0;
  logic [12:0] preload_val = '0;
  logic [12:0] cnt = '0;
  assign CntValue = cnt;
  always @(posedge Clock) begin
    if (CntReset)         cnt <= '0;
    else if (preload_req) cnt <= preload_val;
    else if (CntEnable)   cnt <= cnt + 13'd1;
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // reference LFSR: polynomial x^16+x^14+x^13+x^11+1, seed ACE1
  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction
  logic [15:0] lfsr_m;
  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) lfsr_m <= 16'hACE1;
    else         lfsr_m <= ref_lfsr_next(lfsr_m);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int want);
    total_cnt++;
    if (act == want) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, want);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  typedef struct {
    logic [2:0]  kind;   // {ResultValid, Foul, Timeout}
    logic [12:0] res;
  } exp_t;
  exp_t        exp_q[$];
  logic [12:0] last_result = '0;
  bit          led_seen = 0;
  bit          ce_seen = 0;
  logic [2:0]  prev_flags = '0;

  always @(negedge Clock) begin
    logic [2:0] f;
    exp_t       e;
    f = {ResultValid, Foul, Timeout};
    if (ResetN) begin
      if (Led)       led_seen = 1;
      if (CntEnable) ce_seen = 1;
      if (f != 3'b000 && prev_flags == 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_outcome", int'(f), 0);
        end else begin
          e = exp_q.pop_front();
          chk("outcome_kind", int'(f), int'(e.kind));
          chk("outcome_result", int'(Result), int'(e.res));
        end
      end
    end
    prev_flags = f;
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge Clock);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge Clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic start_round(output int w, output int p0);
    @(negedge Clock);
    w = MIN_WAIT_MS + int'(lfsr_m[9:0]);
    Start = 1'b1;
    @(negedge Clock);
    p0 = cyc;
    Start = 1'b0;
    led_seen = 0;
    ce_seen = 0;
    chk("cntreset_on_arm", int'(CntReset), 1);
    chk("busy_in_arm", int'(Busy), 1);
    chk("flags_cleared", int'({ResultValid, Foul, Timeout}), 0);
    @(negedge Clock);
    chk("cntreset_one_cycle", int'(CntReset), 0);
  endtask

  task automatic wait_led(input int p0, input int w, output int g, output bit ok);
    ok = 0;
    g = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      if (Led) begin
        ok = 1;
        g = cyc;
      end else begin
        @(negedge Clock);
      end
    end
    if (!ok) chk("led_rise", 0, 1);
    else     chk_range("led_delay", g - p0, w * TICK_DIV - 1, w * TICK_DIV + 1);
  endtask

  task automatic round_normal(input int k);
    int w, p0, g;
    bit ok;
    start_round(w, p0);
    Start = 1'b1;                  // ignored in ARM
    @(negedge Clock);
    Start = 1'b0;
    wait_led(p0, w, g, ok);
    if (!ok) return;
    @(negedge Clock);
    Start = 1'b1;                  // ignored in GO
    @(negedge Clock);
    Start = 1'b0;
    wait_until(g + k * TICK_DIV);
    exp_q.push_back('{3'b100, 13'(k)});
    last_result = 13'(k);
    Button = 1'b1;
    repeat (3) @(negedge Clock);
    Button = 1'b0;
    drain();
    chk("led_off_after_done", int'(Led), 0);
    chk("busy_off_after_done", int'(Busy), 0);
  endtask

  task automatic round_foul();
    int w, p0, j;
    start_round(w, p0);
    j = int'($urandom_range(w * TICK_DIV - 3, 0));
    wait_until(p0 + 1 + j);
    exp_q.push_back('{3'b010, last_result});
    Button = 1'b1;
    repeat (2) @(negedge Clock);
    Button = 1'b0;
    drain();
    repeat (2 * TICK_DIV) @(negedge Clock);
    chk("foul_led_never", int'(led_seen), 0);
    chk("foul_cnten_never", int'(ce_seen), 0);
    chk("foul_result_kept", int'(Result), int'(last_result));
  endtask

  task automatic round_foul_on_expiry();
    int w, p0;
    start_round(w, p0);
    wait_until(p0 + w * TICK_DIV - 1);
    exp_q.push_back('{3'b010, last_result});
    Button = 1'b1;
    repeat (2) @(negedge Clock);
    Button = 1'b0;
    drain();
    chk("expiry_foul_led_never", int'(led_seen), 0);
  endtask

  task automatic round_top(input bit press_on_tick);
    int w, p0, g, m;
    bit ok;
    start_round(w, p0);
    wait_led(p0, w, g, ok);
    if (!ok) return;
    m = int'($urandom_range(8, 3));
    preload_val = 13'(8191 - m);
    preload_req = 1'b1;
    @(negedge Clock);
    preload_req = 1'b0;
    if (press_on_tick) begin
      wait_until(g + m * TICK_DIV + TICK_DIV - 1);
      exp_q.push_back('{3'b100, 13'h1FFF});
      last_result = 13'h1FFF;
      Button = 1'b1;
      repeat (2) @(negedge Clock);
      Button = 1'b0;
    end else begin
      exp_q.push_back('{3'b001, last_result});
    end
    drain();
    ce_seen = 0;
    repeat (5 * TICK_DIV) @(negedge Clock);
    chk("top_cnten_stopped", int'(ce_seen), 0);
    chk("top_cnt_held", int'(CntValue), 8191);
  endtask

  task automatic round_reset_mid_go();
    int w, p0, g;
    bit ok;
    start_round(w, p0);
    wait_led(p0, w, g, ok);
    if (!ok) return;
    for (int i = 0; i < 1000 && CntValue != 13'd100; i++) @(negedge Clock);
    chk("cnt_reached_100", int'(CntValue), 100);
    Start = 1'b1;
    #1 ResetN = 1'b0;
    #1;
    chk("rst_led", int'(Led), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_cnten", int'(CntEnable), 0);
    chk("rst_cntreset", int'(CntReset), 1);
    chk("rst_flags", int'({ResultValid, Foul, Timeout}), 0);
    chk("rst_result", int'(Result), 0);
    last_result = '0;
    repeat (3) @(negedge Clock);
    ResetN = 1'b1;
    repeat (10) @(negedge Clock);
    chk("held_start_idle_busy", int'(Busy), 0);
    chk("held_start_idle_cntreset", int'(CntReset), 0);
    Start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    chk("reset_cntreset", int'(CntReset), 1);
    chk("reset_led", int'(Led), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_cnten", int'(CntEnable), 0);
    chk("reset_flags", int'({ResultValid, Foul, Timeout}), 0);
    chk("reset_result", int'(Result), 0);
    ResetN = 1'b1;
    repeat (int'($urandom_range(20, 3))) @(negedge Clock);
    chk("idle_after_reset", int'(Busy), 0);
    round_normal(25);
    round_normal(int'($urandom_range(40, 1)));
    round_foul();
    round_foul_on_expiry();
    round_normal(int'($urandom_range(40, 1)));
    round_top(1'b0);
    round_top(1'b1);
    round_normal(int'($urandom_range(40, 1)));
    round_reset_mid_go();
    round_normal(3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
